// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: datapath width, canonical NOP and the
// fetch/decode skid-buffer state encoding.
package riscv_pkg;

  localparam int DEFAULT_XLEN = 32;
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } fd_state_t;

endpackage

// File: rtl/flopenrc.sv
// Register with enable and synchronous clear; reset is synchronous active-low.
module flopenrc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!reset)   q <= '0;
    else if (clr) q <= '0;
    else if (en)  q <= d;
  end

endmodule

// File: rtl/pipeline_fd.sv
// Fetch-to-decode pipeline register with a one-entry skid buffer, so ReadyF
// depends only on registered state and never on StallD.
module pipeline_fd
  import riscv_pkg::*;
#(
  parameter int              XLEN      = DEFAULT_XLEN,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(DEFAULT_NOP_INSTR)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] InstrF,
  input  logic [XLEN-1:0] PCF,
  input  logic [XLEN-1:0] PCPlus4F,
  input  logic            ValidF,
  output logic            ReadyF,
  input  logic            StallD,
  input  logic            FlushD,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
);

  fd_state_t state;
  fd_state_t state_next;

  logic            accept;
  logic            release_main;
  logic            main_en;
  logic            skid_en;
  logic            from_skid;
  logic [XLEN-1:0] main_instr;
  logic [XLEN-1:0] skid_instr;
  logic [XLEN-1:0] skid_pc;
  logic [XLEN-1:0] skid_pc4;
  logic [XLEN-1:0] main_instr_d;
  logic [XLEN-1:0] main_pc_d;
  logic [XLEN-1:0] main_pc4_d;

  assign ReadyF       = (state != TWO);
  assign ValidD       = (state != EMPTY);
  assign accept       = ValidF && ReadyF;
  assign release_main = ValidD && !StallD;

  always_comb begin
    state_next = state;
    main_en    = 1'b0;
    skid_en    = 1'b0;
    from_skid  = 1'b0;
    if (FlushD) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_next = ONE;
            main_en    = 1'b1;
          end
        end
        ONE: begin
          if (accept && release_main) begin
            main_en = 1'b1;
          end else if (accept) begin
            state_next = TWO;
            skid_en    = 1'b1;
          end else if (release_main) begin
            state_next = EMPTY;
          end
        end
        TWO: begin
          if (release_main) begin
            state_next = ONE;
            main_en    = 1'b1;
            from_skid  = 1'b1;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= EMPTY;
    else        state <= state_next;
  end

  assign main_instr_d = from_skid ? skid_instr : InstrF;
  assign main_pc_d    = from_skid ? skid_pc    : PCF;
  assign main_pc4_d   = from_skid ? skid_pc4   : PCPlus4F;

  // Main entry is not cleared on flush so PCD/PCPlus4D keep their last values.
  flopenrc #(.WIDTH(XLEN)) u_main_instr (
    .clk(clk), .reset(reset), .en(main_en), .clr(1'b0), .d(main_instr_d), .q(main_instr)
  );
  flopenrc #(.WIDTH(XLEN)) u_main_pc (
    .clk(clk), .reset(reset), .en(main_en), .clr(1'b0), .d(main_pc_d), .q(PCD)
  );
  flopenrc #(.WIDTH(XLEN)) u_main_pc4 (
    .clk(clk), .reset(reset), .en(main_en), .clr(1'b0), .d(main_pc4_d), .q(PCPlus4D)
  );

  flopenrc #(.WIDTH(XLEN)) u_skid_instr (
    .clk(clk), .reset(reset), .en(skid_en), .clr(FlushD), .d(InstrF), .q(skid_instr)
  );
  flopenrc #(.WIDTH(XLEN)) u_skid_pc (
    .clk(clk), .reset(reset), .en(skid_en), .clr(FlushD), .d(PCF), .q(skid_pc)
  );
  flopenrc #(.WIDTH(XLEN)) u_skid_pc4 (
    .clk(clk), .reset(reset), .en(skid_en), .clr(FlushD), .d(PCPlus4F), .q(skid_pc4)
  );

  assign InstrD = ValidD ? main_instr : NOP_INSTR;

endmodule

// File: doc/pipeline_fd.md
PIPELINE_FD -- requirements
Module: pipeline_fd

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width of instruction, PC and PC+4 fields.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h00000013 (addi x0,x0,0), the instruction presented when no valid entry exists.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-low reset (reset==0 at a rising clk edge resets the block).
REQ-005 SHALL have port InstrF, input, XLEN, fetched instruction.
REQ-006 SHALL have port PCF, input, XLEN, PC of InstrF.
REQ-007 SHALL have port PCPlus4F, input, XLEN, PCF+4 from fetch.
REQ-008 SHALL have port ValidF, input, 1, fetch beat valid.
REQ-009 SHALL have port ReadyF, output, 1, block can accept a fetch beat.
REQ-010 SHALL have port StallD, input, 1, decode cannot consume the current D beat.
REQ-011 SHALL have port FlushD, input, 1, discard all held and incoming beats (taken branch/jump).
REQ-012 SHALL have ports InstrD, PCD, PCPlus4D, outputs, XLEN each, registered beat toward decode.
REQ-013 SHALL have port ValidD, output, 1, D outputs hold a valid beat.

Function
REQ-014 SHALL hold up to two beats: main entry (drives D outputs) and skid entry; state EMPTY, ONE, TWO.
REQ-015 SHALL accept a beat when ValidF && ReadyF; SHALL release the main beat when ValidD && !StallD.
REQ-016 SHALL drive ReadyF = (state != TWO), from registered state only, no combinational path from StallD.
REQ-017 EMPTY: accept -> ONE, beat loaded into main; otherwise stay.
REQ-018 ONE: accept&release -> ONE, main replaced by new beat; accept&!release -> TWO, beat loaded into skid; release only -> EMPTY; neither -> stay, main unchanged.
REQ-019 TWO: release -> ONE, skid moved to main; otherwise stay, both entries unchanged.
REQ-020 SHALL give one-cycle latency: beat accepted at edge k appears on D outputs after edge k when state was EMPTY, or main released at edge k.
REQ-021 SHALL preserve beat order; no beat duplicated or dropped except by flush.
REQ-022 FlushD SHALL have priority over StallD and accept: next state EMPTY, both entries invalidated, the beat offered in the flush cycle discarded.
REQ-023 SHALL drive InstrD = NOP_INSTR whenever ValidD==0; PCD/PCPlus4D hold last values when invalid.
REQ-024 ValidD SHALL equal (state != EMPTY).

Reset
REQ-025 On reset: state EMPTY, ValidD=0, ReadyF=1, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, skid contents 0.
REQ-026 Reset SHALL override FlushD, StallD and ValidF in the same cycle; a beat in flight is lost.

Structure
REQ-027 XLEN default, NOP_INSTR constant and the fd_state_t enum (EMPTY, ONE, TWO) SHALL live in shared package riscv_pkg.
REQ-028 Each entry SHALL be built from sub-module flopenrc (flop with enable and synchronous clear), one instance per field per entry.

Verification
REQ-029 Reset: reset=0 one cycle -> ValidD=0, ReadyF=1, InstrD=32'h00000013, PCD=0.
REQ-030 Streaming: ValidF=1, StallD=0, PCF=0x0,0x4,0x8 on consecutive cycles -> PCD=0x0,0x4,0x8 one cycle later each, ReadyF stays 1.
REQ-031 Stall fill: StallD=1, beats PCF=0x10,0x14,0x18 offered -> 0x10,0x14 accepted, ReadyF=0 after second, 0x18 held off; StallD=0 -> PCD 0x10 then 0x14 then 0x18.
REQ-032 Flush in TWO: state TWO (0x20 main, 0x24 skid), FlushD=1 with ValidF=1 PCF=0x28 -> next cycle ValidD=0, InstrD=NOP, ReadyF=1; 0x28 never appears.
REQ-033 Flush+stall: FlushD=1, StallD=1 in ONE -> EMPTY next cycle.
REQ-034 Reset mid-operation: state TWO, reset=0 with ValidF=1 -> EMPTY, outputs at reset values, no stale beat after reset released.
